// File: rtl/dds_phase_gen.sv
// Phase accumulator for a table-lookup DDS. Frequency changes made while running are deferred to
// the next accumulator wrap so the new tone starts phase-continuously at phase zero.
module dds_phase_gen #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned L      = 256,
  parameter int unsigned ADDR_W = $clog2(L)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              phase_sync,
  input  logic              freq_load,
  input  logic [ACC_W-1:0]  freq_word,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              data_valid,
  output logic              wrap,
  output logic              freq_ack,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] active_word_q;
  logic [ACC_W-1:0] pending_word_q;
  logic             pending_flag_q;
  logic             addr_valid_q;
  logic             data_valid_q;
  logic             wrap_q;
  logic             freq_ack_q;
  logic             busy_q;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             stop_done;

  assign sum = {1'b0, acc_q} + {1'b0, active_word_q};
  // phase_sync replaces the increment, so it also suppresses the carry
  assign carry = sum[ACC_W] & ~phase_sync;
  // a zero tuning word never wraps, so a pending stop completes immediately
  assign stop_done = (state_q == StStop) && !start && (carry || (active_word_q == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      active_word_q  <= '0;
      pending_word_q <= '0;
      pending_flag_q <= 1'b0;
      addr_valid_q   <= 1'b0;
      data_valid_q   <= 1'b0;
      wrap_q         <= 1'b0;
      freq_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      data_valid_q <= addr_valid_q;
      wrap_q       <= 1'b0;
      freq_ack_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          acc_q          <= '0;
          pending_flag_q <= 1'b0;
          if (freq_load) begin
            active_word_q <= freq_word;
            freq_ack_q    <= 1'b1;
          end
          if (start) begin
            state_q      <= StRun;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StRun, StStop: begin
          if (stop_done) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            pending_flag_q <= 1'b0;
            addr_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            wrap_q         <= carry;
          end else begin
            acc_q        <= phase_sync ? '0 : sum[ACC_W-1:0];
            wrap_q       <= carry;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            if (carry && pending_flag_q) begin
              active_word_q  <= pending_word_q;
              freq_ack_q     <= 1'b1;
              pending_flag_q <= 1'b0;
            end
            // a load coinciding with the carry becomes the next pending word
            if (freq_load) begin
              pending_word_q <= freq_word;
              pending_flag_q <= 1'b1;
            end
            if (start) begin
              state_q <= StRun;
            end else if (stop) begin
              state_q <= StStop;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr       = acc_q[ACC_W-1 -: ADDR_W];
  assign addr_valid = addr_valid_q;
  assign data_valid = data_valid_q;
  assign wrap       = wrap_q;
  assign freq_ack   = freq_ack_q;
  assign busy       = busy_q;

endmodule
